rom_addr_seq22: RTL and testbench
=================================

Name: rom_addr_seq22

Overview:
- 22-bit ROM address sequencer; sits directly downstream of the 16-bit-to-22-bit split stage.
- Loads a start address from the 22 split bits (D21..D0, with D21..D16 zero from a 16-bit source) and emits a burst of sequential addresses.
- Downstream ROM fetch logic can throttle the burst with a stall input.
- Reports busy and done status to the controlling state machine.

Parameters:
- STEP, 1, address increment per accepted beat (1..255).
- ADDR_W, 22, address width; fixed at 22 for this stage, parameterised for reuse only.

Ports:
- CLK  input  1  system clock, rising edge.
- nRESET  input  1  asynchronous active-low reset.
- LOAD  input  1  load ADDR from LOAD_D this cycle.
- LOAD_D  input  22  start address; bit n is split-stage output Dn.
- BURST_LEN  input  8  beats per burst, sampled on START; 0 means 256.
- START  input  1  begin a burst; honoured only in IDLE.
- STALL  input  1  downstream not ready; current beat is held.
- ADDR  output  22  current address.
- ADDR_VALID  output  1  ADDR is a live burst beat.
- BUSY  output  1  high in RUN and DONE states.
- DONE  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Single clock domain; clock port CLK, reset port nRESET, asynchronous assert and active-low.
- Reset values: ADDR=0, ADDR_VALID=0, BUSY=0, DONE=0, state=IDLE, remaining count=0.
- Reset release is synchronous to CLK by the integrating design.
- States:
  - IDLE: waits for LOAD or START.
  - RUN: emits beats.
  - DONE: one cycle, then IDLE.
- IDLE:
  - LOAD=1: ADDR<=LOAD_D on the next edge.
  - START=1 with LOAD=0: remaining<=BURST_LEN (0 maps to 256), go to RUN.
  - LOAD and START together: LOAD wins, START is dropped, state stays IDLE.
- RUN:
  - ADDR_VALID=1 throughout.
  - A beat is accepted on every edge where STALL=0. On acceptance: ADDR<=ADDR+STEP and remaining<=remaining-1.
  - STALL=1: ADDR, remaining and ADDR_VALID are held.
  - Acceptance with remaining=1: go to DONE; ADDR holds the post-increment value.
- DONE: ADDR_VALID=0, DONE=1, BUSY=1 for exactly one cycle, then IDLE.
- Latency: START edge -> first ADDR_VALID cycle is 1 clock. N-beat burst with no stalls -> DONE asserted N+1 clocks after START is sampled.
- Arithmetic: ADDR increments modulo 2^22. 0x3FFFFF+1 -> 0x000000 with no error flag.
- LOAD during RUN: aborts the burst. Next edge: ADDR<=LOAD_D, state=IDLE, ADDR_VALID=0, no DONE pulse.
- LOAD during DONE: ADDR<=LOAD_D; DONE still completes its single cycle.
- START outside IDLE: ignored.
- Reset mid-burst: all outputs return to reset values immediately, with no DONE pulse.

Optional Feature:
- Macro: ROM_ADDR_SEQ22_PAGE_WRAP_EN.
- Defined:
  - The increment applies to ADDR[15:0] only, modulo 2^16; ADDR[21:16] holds its loaded value.
  - Example: ADDR 0x01FFFF + 1 -> 0x010000.
  - Matches 64K-word page banking of 16-bit sources.
- Undefined: full 22-bit increment as in Behaviour.
- Port list is identical either way.

Test Plan:
- Reset and load: assert nRESET=0 mid-cycle -> outputs 0 immediately. Release, LOAD with LOAD_D=0x001234 -> ADDR=0x001234, ADDR_VALID=0.
- Basic burst: load 0x000100, START with BURST_LEN=4, STEP=1, STALL=0 -> ADDR_VALID for 4 cycles showing 0x100,0x101,0x102,0x103. DONE pulses one cycle with ADDR=0x104, then BUSY=0.
- Stall: same burst with STALL=1 for 3 cycles on beat 2 -> ADDR held at 0x101 for those cycles. Total of 4 accepted beats; DONE is 3 cycles later than in the no-stall case.
- Wrap and length-0 burst: load 0x3FFFFE, START with BURST_LEN=0 -> 256 beats, with ADDR wrapping 0x3FFFFF -> 0x000000. Final ADDR is 0x0000FE.
  - With ROM_ADDR_SEQ22_PAGE_WRAP_EN defined: load 0x01FFFE -> 0x01FFFF then 0x010000.
- Simultaneous events: LOAD and START in the same IDLE cycle -> address loaded, no burst.
  - LOAD=0x000500 during RUN -> ADDR=0x000500, IDLE, no DONE pulse.
- Reset mid-burst: nRESET low during RUN beat 2 -> ADDR=0, BUSY=0, no DONE pulse. Next START works normally.

Source files
------------

// File: rtl/rom_addr_seq22.sv
// 22-bit ROM address sequencer: loads a start address and emits a stallable burst.
// Optional 64K page wrap of the increment: define ROM_ADDR_SEQ22_PAGE_WRAP_EN.
module rom_addr_seq22 #(
  parameter int STEP   = 1,
  parameter int ADDR_W = 22
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              LOAD,
  input  logic [ADDR_W-1:0] LOAD_D,
  input  logic [7:0]        BURST_LEN,
  input  logic              START,
  input  logic              STALL,
  output logic [ADDR_W-1:0] ADDR,
  output logic              ADDR_VALID,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        rem_q, rem_d;
  logic [ADDR_W-1:0] addr_inc;

`ifdef ROM_ADDR_SEQ22_PAGE_WRAP_EN
  // Upper bits keep the loaded page; only the low 16 bits count.
  assign addr_inc = {addr_q[ADDR_W-1:16], addr_q[15:0] + 16'(STEP)};
`else
  assign addr_inc = addr_q + ADDR_W'(STEP);
`endif

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          addr_d = LOAD_D;
        end else if (START) begin
          rem_d   = (BURST_LEN == 8'd0) ? 9'd256 : {1'b0, BURST_LEN};
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (LOAD) begin
          addr_d  = LOAD_D;
          rem_d   = '0;
          state_d = S_IDLE;
        end else if (!STALL) begin
          addr_d = addr_inc;
          rem_d  = rem_q - 9'd1;
          if (rem_q == 9'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (LOAD) addr_d = LOAD_D;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ADDR       = addr_q;
  assign ADDR_VALID = (state_q == S_RUN);
  assign BUSY       = (state_q == S_RUN) || (state_q == S_DONE);
  assign DONE       = (state_q == S_DONE);

endmodule

// File: tb/tb_rom_addr_seq22.sv
// Directed bench for rom_addr_seq22: load, bursts, stall, wrap, abort, reset.
module tb_rom_addr_seq22;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        LOAD;
  logic [21:0] LOAD_D;
  logic [7:0]  BURST_LEN;
  logic        START;
  logic        STALL;
  logic [21:0] ADDR;
  logic        ADDR_VALID;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int failures = 0;
  int n;

  rom_addr_seq22 dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .LOAD       (LOAD),
    .LOAD_D     (LOAD_D),
    .BURST_LEN  (BURST_LEN),
    .START      (START),
    .STALL      (STALL),
    .ADDR       (ADDR),
    .ADDR_VALID (ADDR_VALID),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [21:0] a);
    LOAD = 1'b1;
    LOAD_D = a;
    step();
    LOAD = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] len);
    START = 1'b1;
    BURST_LEN = len;
    step();
    START = 1'b0;
  endtask

  // Cycles from the first RUN cycle until DONE is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!DONE && cyc < 600) begin
      step();
      cyc++;
    end
  endtask

  task automatic chk_out(input string tag, input logic [21:0] a,
                         input logic v, input logic b, input logic d);
    chk({tag, ".addr"}, 32'(ADDR), 32'(a));
    chk({tag, ".valid"}, 32'(ADDR_VALID), 32'(v));
    chk({tag, ".busy"}, 32'(BUSY), 32'(b));
    chk({tag, ".done"}, 32'(DONE), 32'(d));
  endtask

  initial begin
    nRESET = 1'b0;
    LOAD = 1'b0;
    LOAD_D = '0;
    BURST_LEN = '0;
    START = 1'b0;
    STALL = 1'b0;
    step();
    step();
    chk_out("reset", 22'h0, 1'b0, 1'b0, 1'b0);
    nRESET = 1'b1;
    step();

    do_load(22'h001234);
    chk_out("load", 22'h001234, 1'b0, 1'b0, 1'b0);

    // Basic 4-beat burst
    do_load(22'h000100);
    do_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("beat%0d", i), 22'h000100 + 22'(i), 1'b1, 1'b1, 1'b0);
      step();
    end
    chk_out("done", 22'h000104, 1'b0, 1'b1, 1'b1);
    step();
    chk_out("post_done", 22'h000104, 1'b0, 1'b0, 1'b0);

    // No-stall latency reference
    do_load(22'h000100);
    do_start(8'd4);
    wait_done(n);
    chk("lat_nostall", 32'(n), 32'd4);
    step();

    // Stall three cycles on beat 2
    do_load(22'h000100);
    do_start(8'd4);
    chk("st_b1", 32'(ADDR), 32'h100);
    step();
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_hold%0d", i), 32'(ADDR), 32'h101);
      chk($sformatf("st_valid%0d", i), 32'(ADDR_VALID), 32'd1);
      step();
    end
    STALL = 1'b0;
    chk("st_b2", 32'(ADDR), 32'h101);
    wait_done(n);
    chk("lat_stall", 32'(n), 32'd3);
    chk("st_final", 32'(ADDR), 32'h104);
    step();

    // Length-0 burst (256 beats) crossing the address wrap
`ifdef ROM_ADDR_SEQ22_PAGE_WRAP_EN
    do_load(22'h01FFFE);
    do_start(8'd0);
    step();
    chk("wrap_a", 32'(ADDR), 32'h01FFFF);
    step();
    chk("wrap_b", 32'(ADDR), 32'h010000);
    wait_done(n);
    chk("wrap_n", 32'(n), 32'd254);
    chk("wrap_fin", 32'(ADDR), 32'h0100FE);
`else
    do_load(22'h3FFFFE);
    do_start(8'd0);
    step();
    chk("wrap_a", 32'(ADDR), 32'h3FFFFF);
    step();
    chk("wrap_b", 32'(ADDR), 32'h000000);
    chk("wrap_v", 32'(ADDR_VALID), 32'd1);
    wait_done(n);
    chk("wrap_n", 32'(n), 32'd254);
    chk("wrap_fin", 32'(ADDR), 32'h0000FE);
    step();
    do_load(22'h01FFFF);
    do_start(8'd1);
    step();
    chk("carry16", 32'(ADDR), 32'h020000);
`endif
    step();

    // LOAD and START together in IDLE
    LOAD = 1'b1;
    LOAD_D = 22'h000777;
    do_start(8'd2);
    LOAD = 1'b0;
    chk_out("ld_st", 22'h000777, 1'b0, 1'b0, 1'b0);
    step();
    chk("ld_st_idle", 32'(BUSY), 32'd0);

    // LOAD during RUN aborts without DONE
    do_load(22'h000200);
    do_start(8'd8);
    step();
    chk("abort_pre", 32'(ADDR), 32'h201);
    do_load(22'h000500);
    chk_out("abort", 22'h000500, 1'b0, 1'b0, 1'b0);
    step();
    chk("abort_nodone", 32'(DONE), 32'd0);

    // LOAD during DONE
    do_start(8'd1);
    chk("ldd_run", 32'(ADDR), 32'h500);
    step();
    chk_out("ldd_done", 22'h000501, 1'b0, 1'b1, 1'b1);
    do_load(22'h000900);
    chk_out("ldd_after", 22'h000900, 1'b0, 1'b0, 1'b0);

    // START during RUN is ignored
    do_start(8'd2);
    START = 1'b1;
    BURST_LEN = 8'd50;
    step();
    START = 1'b0;
    chk("st_ign_a", 32'(ADDR), 32'h901);
    step();
    chk("st_ign_done", 32'(DONE), 32'd1);
    chk("st_ign_fin", 32'(ADDR), 32'h902);
    step();

    // Reset during beat 2
    do_load(22'h000100);
    do_start(8'd4);
    step();
    chk("rst_pre", 32'(ADDR), 32'h101);
    nRESET = 1'b0;
    #1;
    chk_out("rst_mid", 22'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("rst_nodone", 32'(DONE), 32'd0);
    nRESET = 1'b1;
    step();
    do_load(22'h000040);
    do_start(8'd2);
    wait_done(n);
    chk("rst_again_n", 32'(n), 32'd2);
    chk("rst_again_a", 32'(ADDR), 32'h42);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
